// File: rtl/riscv_enc_pkg.sv
// riscv_enc_pkg: shared opcodes, request kinds, FSM states and immediate limits
package riscv_enc_pkg;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam int IMM12_MIN = -2048;
    localparam int IMM12_MAX = 2047;
    localparam int BEQ_MIN   = -4096;
    localparam int BEQ_MAX   = 4094;
    localparam int JAL_MIN   = -1048576;
    localparam int JAL_MAX   = 1048574;

    typedef enum logic [2:0] {
        K_R   = 3'd0,
        K_I   = 3'd1,
        K_LW  = 3'd2,
        K_SW  = 3'd3,
        K_BEQ = 3'd4,
        K_JAL = 3'd5,
        K_END = 3'd6,
        K_ILL = 3'd7
    } req_kind_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCEPT = 2'd1,
        S_WRITE  = 2'd2,
        S_DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/instr_field_packer.sv
// instr_field_packer: packs request fields into an RV32I word and checks immediate range
module instr_field_packer
    import riscv_enc_pkg::*;
(
    input  logic [2:0]  kind,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [20:0] imm,
    output logic [31:0] word,
    output logic        range_ok
);

    logic signed [20:0] simm;
    logic               fits12;
    logic               fits_b;
    logic               fits_j;

    assign simm   = $signed(imm);
    assign fits12 = simm >= IMM12_MIN && simm <= IMM12_MAX;
    assign fits_b = simm >= BEQ_MIN && simm <= BEQ_MAX && !imm[0];
    assign fits_j = simm >= JAL_MIN && simm <= JAL_MAX && !imm[0];

    // Scatter fields by format; END and illegal kinds produce an all-zero word
    always_comb begin
        word     = '0;
        range_ok = 1'b0;
        case (req_kind_e'(kind))
            K_R:   begin word = {funct7, rs2, rs1, funct3, rd, OP_R}; range_ok = 1'b1; end
            K_I:   begin word = {imm[11:0], rs1, funct3, rd, OP_I}; range_ok = fits12; end
            K_LW:  begin word = {imm[11:0], rs1, 3'b010, rd, OP_LW}; range_ok = fits12; end
            K_SW:  begin word = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_SW}; range_ok = fits12; end
            K_BEQ: begin word = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], OP_BEQ}; range_ok = fits_b; end
            K_JAL: begin word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL}; range_ok = fits_j; end
            default: begin word = '0; range_ok = 1'b0; end
        endcase
    end

endmodule

// File: rtl/instr_encode_loader.sv
// instr_encode_loader: accepts field-level requests and writes encoded words to instruction memory
module instr_encode_loader
    import riscv_enc_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_kind,
    input  logic [2:0]        req_funct3,
    input  logic [6:0]        req_funct7,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [20:0]       req_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(2**ADDR_W);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       word_q, word_d, word;
    logic              ok_q, ok_d, err_q, err_d, range_ok;
    req_kind_e         kind;

    assign kind = req_kind_e'(req_kind);

    instr_field_packer u_packer (
        .kind     (req_kind),
        .funct3   (req_funct3),
        .funct7   (req_funct7),
        .rd       (req_rd),
        .rs1      (req_rs1),
        .rs2      (req_rs2),
        .imm      (req_imm),
        .word     (word),
        .range_ok (range_ok)
    );

    // Next-state logic: one handshake in ACCEPT, one write slot in WRITE; address holds once full
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        addr_d  = addr_q;
        word_d  = word_q;
        ok_d    = ok_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_ACCEPT;
                count_d = '0;
                addr_d  = '0;
                err_d   = 1'b0;
            end
            S_ACCEPT: if (req_valid) begin
                if (kind == K_END) state_d = S_DONE;
                else if (kind == K_ILL) err_d = 1'b1;
                else begin
                    word_d  = word;
                    ok_d    = range_ok;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: if (!ok_q) begin
                err_d   = 1'b1;
                state_d = S_ACCEPT;
            end else begin
                count_d = count_q + 1'b1;
                state_d = (count_d == FULL) ? S_DONE : S_ACCEPT;
                addr_d  = (count_d == FULL) ? addr_q : addr_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset drops any pending write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            addr_q  <= '0;
            word_q  <= '0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
        end
    end

    assign req_ready  = state_q == S_ACCEPT;
    assign imem_we    = state_q == S_WRITE && ok_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = word_q;
    assign busy       = state_q != S_IDLE;
    assign done       = state_q == S_DONE;
    assign err        = err_q;
    assign count      = count_q;

endmodule

// File: doc/instr_encode_loader.md
# instr_encode_loader

Sequential RV32I instruction encoder and instruction-memory loader, the encode-side counterpart of the core's control-path decoder. It accepts field-level instruction requests over a valid/ready handshake and packs each one into a 32-bit machine word. Every opcode and immediate format the main decoder recognises is supported: R, I-ALU, lw, sw, beq and jal. Each word is written into instruction memory at a sequential word address. It sits beside the pipeline and is used by the bench and boot logic to preload programs before the core leaves reset.

## Interface
- ADDR_W, 8, instruction-memory word-address width; DEPTH = 2**ADDR_W words
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  opens a load session; honoured only in IDLE
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_kind  in  3  R=0, I=1, LW=2, SW=3, BEQ=4, JAL=5, END=6; 7 is illegal
- req_funct3  in  3  funct3 for R and I requests; forced 010 for LW/SW and 000 for BEQ
- req_funct7  in  7  funct7 for R requests; ignored otherwise
- req_rd, req_rs1, req_rs2  in  5 each  register fields
- req_imm  in  21  signed byte offset or immediate
- imem_we  out  1  write strobe, one cycle per word
- imem_addr  out  ADDR_W  word address
- imem_wdata  out  32  encoded instruction
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse at session end
- err  out  1  sticky error; cleared by the next accepted start
- count  out  ADDR_W+1  words written this session

## Operation
- FSM states are IDLE, ACCEPT, WRITE and DONE.
- IDLE + start: go to ACCEPT; clear count, imem_addr and err.
- ACCEPT: req_ready=1. On handshake, register the encoded word and the range check, then go to WRITE.
  - END: go to DONE; nothing is written.
  - Illegal kind: set err and go to ACCEPT; nothing is written.
- WRITE: assert imem_we with the registered word, then return to ACCEPT.
  - If the range check failed: no write, set err, count unchanged.
  - On a valid write: count++ and imem_addr++.
  - If count reaches DEPTH: go to DONE instead of ACCEPT.
- DONE: pulse done for one cycle, then go to IDLE.
- Opcodes: R 0110011, I 0010011, LW 0000011, SW 0100011, BEQ 1100011, JAL 1101111.
- Immediate legality:
  - I/LW/SW: value in [-2048, 2047].
  - BEQ: value in [-4096, 4094] and even.
  - JAL: value in [-1048576, 1048574] and even.
- Formats are standard RV32I I/S/B/J bit scattering. rd is 0 for SW/BEQ. rs1 and rs2 are 0 where the format has no such field.

## Timing
- Reset values: req_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, busy 0, done 0, err 0, count 0, state IDLE.
- Latency: handshake in cycle N, imem_we in cycle N+1. Throughput is one word per 2 cycles.
- req_ready is low in WRITE, DONE and IDLE, so no back-to-back acceptance.
- imem_addr and imem_wdata are stable while imem_we is high. imem_addr advances on the cycle after the write.
- start outside IDLE is ignored, including in DONE.
- Full: the request that fills the last word ends the session through DONE. No wrap-around.
- Reset mid-session: any pending write is discarded and all outputs return to their reset values. Memory contents are untouched.
- done and the WRITE-to-DONE transition coincide with no extra write.

## Structure
- Package riscv_enc_pkg holds:
  - the opcode localparams;
  - the req_kind_e enum;
  - the state_e enum;
  - the immediate-limit constants.
- Sub-module instr_field_packer: purely combinational. It takes the request fields and returns the 32-bit word plus a range_ok flag. The FSM and counters stay in instr_encode_loader.

## Test plan
- R add x3,x1,x2 (f3 0, f7 0) -> imem_wdata 0x002081B3 at addr 0, count 1.
- I addi x5,x0,-1 followed by SW x2,8(x1) -> 0xFFF00293 at addr 0, then 0x0020A423 at addr 1.
- BEQ rs1 1, rs2 2, imm -4, followed by JAL rd 1, imm 2048 -> 0xFE208EE3, then 0x001000EF.
- Range and illegal cases, each with err=1, no imem_we and count unchanged; a following valid request still writes:
  - I imm 2048;
  - BEQ imm 3;
  - req_kind 7.
- ADDR_W=2 with 5 R requests -> 4 writes at addrs 0..3, done pulse after the 4th, 5th request never acknowledged.
- rst asserted in the WRITE cycle -> imem_we 0 immediately, count 0. A new start then writes at addr 0.
